// File: rtl/hex_display_sched_if.sv
// hex_display_sched_if: requester inputs and display outputs of the HEX scheduler.
// HEX_SCHED_SWITCH_CNT_EN adds the switch_cnt debug counter.
interface hex_display_sched_if;
  logic        req0;
  logic [19:0] data0;
  logic        req1;
  logic [19:0] data1;
  logic [1:0]  gnt;
  logic [15:0] hex_digits;
  logic [1:0]  signs;
  logic [1:0]  hundreds;
  logic        busy;
`ifdef HEX_SCHED_SWITCH_CNT_EN
  logic [7:0]  switch_cnt;
  modport master (output req0, data0, req1, data1,
                  input gnt, hex_digits, signs, hundreds, busy, switch_cnt);
  modport slave  (input req0, data0, req1, data1,
                  output gnt, hex_digits, signs, hundreds, busy, switch_cnt);
`else
  modport master (output req0, data0, req1, data1,
                  input gnt, hex_digits, signs, hundreds, busy);
  modport slave  (input req0, data0, req1, data1,
                  output gnt, hex_digits, signs, hundreds, busy);
`endif
endinterface

// File: rtl/hex_display_sched.sv
// hex_display_sched: round-robin HEX display sharing between two requesters with minimum dwell.
// HEX_SCHED_SWITCH_CNT_EN adds an 8-bit ownership-change counter (switch_cnt).
module hex_display_sched #(
  parameter int DWELL = 1000,
  parameter int CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  hex_display_sched_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             rr_last, enter;
  logic [19:0]      word;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (bus.req1 && (!bus.req0 || !rr_last)) ? OWN1 : bus.req0 ? OWN0 : IDLE;
      OWN0:    nxt = (cnt != '0) ? OWN0 : bus.req1 ? OWN1 : bus.req0 ? OWN0 : IDLE;
      OWN1:    nxt = (cnt != '0) ? OWN1 : bus.req0 ? OWN0 : bus.req1 ? OWN1 : IDLE;
      default: nxt = IDLE;
    endcase
    enter = (nxt != state) && (nxt != IDLE);
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_last <= 1'b1;
      word    <= '0;
    end else begin
      state <= nxt;
      cnt   <= enter ? CNT_W'(DWELL - 1) : (cnt != '0) ? cnt - CNT_W'(1) : cnt;
      if (enter) rr_last <= (nxt == OWN1);
      // a released owner leaves its last word on the display
      if (state == OWN0 && bus.req0) word <= bus.data0;
      else if (state == OWN1 && bus.req1) word <= bus.data1;
    end
  assign bus.gnt        = {state == OWN1, state == OWN0};
  assign bus.busy       = state != IDLE;
  assign bus.hundreds   = word[19:18];
  assign bus.signs      = word[17:16];
  assign bus.hex_digits = word[15:0];
`ifdef HEX_SCHED_SWITCH_CNT_EN
  logic [7:0] sw_cnt;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) sw_cnt <= '0;
    else if (enter) sw_cnt <= sw_cnt + 8'd1;
  assign bus.switch_cnt = sw_cnt;
`endif
endmodule

// File: tb/tb_hex_display_sched.sv
// tb_hex_display_sched: directed and random stimulus checked against an owner/age reference model.
module tb_hex_display_sched;
  localparam int DW = 4;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;
  hex_display_sched_if bus();
  hex_display_sched #(.DWELL(DW), .CNT_W(16)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));
  int errs = 0, checks = 0;
  int owner = -1, last = 1, age = 0, m_sw = 0;
  logic [19:0] m_word = '0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    owner = -1; last = 1; age = 0; m_word = '0; m_sw = 0;
  endtask
  task automatic model_step();
    logic r[2];
    logic [19:0] d[2];
    int nw;
    r[0] = bus.req0; r[1] = bus.req1; d[0] = bus.data0; d[1] = bus.data1;
    if (owner >= 0 && r[owner]) m_word = d[owner];
    if (owner < 0) nw = (r[0] && r[1]) ? 1 - last : r[0] ? 0 : r[1] ? 1 : -1;
    else if (age < DW - 1) nw = owner;
    else nw = r[1 - owner] ? 1 - owner : r[owner] ? owner : -1;
    if (nw >= 0 && nw != owner) begin
      age = 0; last = nw; m_sw = (m_sw + 1) % 256;
    end else age++;
    owner = nw;
  endtask
  task automatic check_outputs(string tag);
    check({tag, ".gnt"}, 32'(bus.gnt), owner < 0 ? 0 : 32'(1 << owner));
    check({tag, ".busy"}, 32'(bus.busy), 32'(owner >= 0));
    check({tag, ".word"}, 32'({bus.hundreds, bus.signs, bus.hex_digits}), 32'(m_word));
`ifdef HEX_SCHED_SWITCH_CNT_EN
    check({tag, ".swcnt"}, 32'(bus.switch_cnt), 32'(m_sw));
`endif
  endtask
  task automatic cycle(string tag);
    @(posedge Clk);
    if (Reset_n) model_step();
    @(negedge Clk);
    check_outputs(tag);
  endtask
  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.data0 = '0; bus.data1 = '0;
    model_reset();
    repeat (2) @(negedge Clk);
    check_outputs("reset");
    Reset_n = 1'b1;
    repeat (10) cycle("idle");
    bus.req0 = 1; bus.data0 = 20'hF1234;
    cycle("grant0");
    check("grant0.lat", 32'(bus.gnt), 32'h1);
    cycle("data0");
    check("data0.digits", 32'(bus.hex_digits), 32'h1234);
    bus.req0 = 0;
    repeat (DW + 2) cycle("release0");
    bus.req0 = 1; bus.req1 = 1; bus.data1 = 20'h000AB;
    repeat (6 * DW) cycle("alt");
    bus.req0 = 0; bus.req1 = 0;
    repeat (DW + 2) cycle("drop");
    bus.req1 = 1; bus.data1 = 20'h5A5A5;
    repeat (3) cycle("own1");
    #2 Reset_n = 1'b0;
    #1 model_reset();
    check_outputs("async_rst");
    @(negedge Clk);
    bus.req0 = 1; bus.req1 = 1;
    Reset_n = 1'b1;
    cycle("post_rst");
    check("post_rst.first", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) bus.req0 = ~bus.req0;
      if ($urandom_range(5) == 0) bus.req1 = ~bus.req1;
      bus.data0 = 20'($urandom);
      bus.data1 = 20'($urandom);
      cycle("rand");
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
